instr_stream_encoder: RTL and testbench
=======================================

# instr_stream_encoder

Hardware counterpart of the processor's instruction decoder: accepts a stream of symbolic RV32I instructions (mnemonic code plus register and immediate fields) over a valid/ready handshake. Each instruction is encoded into a 32-bit machine word and written sequentially into instruction memory starting at word 0. It sits between the host or assembler front-end and the `risc_v_processor` instruction memory write port, and loads programs before the core is released from reset.

## Interface
- `AW`, 8: instruction-memory word-address width.
- `DEPTH`, 256: words loadable; must be ≤ 2^AW.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset. The polarity and asynchronous behaviour are fixed; the clock is named `clk` as elsewhere in the codebase.
- `start` in 1: one-cycle pulse; begins a new load at word 0.
- `in_valid` in 1: instruction fields are valid.
- `in_ready` out 1: block accepts this cycle.
- `in_last` in 1: the current instruction is the final one of the program.
- `op_sel` in 5: mnemonic code.
  - 0 ADD, 1 SUB, 2 SLL, 3 XOR, 4 SRL, 5 SRA, 6 OR, 7 AND.
  - 8 ADDI, 9 SLLI, 10 SRLI, 11 SRAI, 12 ORI, 13 ANDI.
  - 14 LB, 15 LH, 16 LW, 17 SB, 18 SH, 19 SW.
  - 20 BEQ, 21 BNE, 22 BLT, 23 BGE, 24 BLTU, 25 BGEU.
  - 26–31 illegal.
- `rd`, `rs1`, `rs2` in 5 each: register indices.
- `imm` in 13: signed immediate or branch byte offset.
- `imem_we` out 1: memory write strobe.
- `imem_addr` out AW: word address.
- `imem_wdata` out 32: encoded word.
- `done` out 1: one-cycle pulse when the load completes.
- `err` out 1: sticky error flag.
- `err_code` out 2: 1 = illegal `op_sel`, 2 = immediate out of range, 3 = overflow.
- `count` out AW+1: words written in the current load.

## Operation
- FSM states: IDLE, LOAD, PAD, FULL, ERR. Reset state is IDLE.
- `start` moves the FSM to LOAD from any state. It clears `count`, `err`, `err_code` and the address pointer.
- `in_ready` = 1 only in LOAD, with `count` < DEPTH and `start` low.
- A handshake (`in_valid` && `in_ready`) encodes fields into these formats:
  - R: funct7|rs2|rs1|f3|rd|0110011. funct7 = 0100000 for SUB and SRA, else 0.
  - I: imm[11:0]|rs1|f3|rd|0010011. For shifts: imm[11:5] = 0100000 for SRAI, else 0; shamt = imm[4:0].
  - Load: I-format, opcode 0000011, f3 000/001/010.
  - Store: imm[11:5]|rs2|rs1|f3|imm[4:0]|0100011.
  - Branch: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|1100011. f3 values: 000, 001, 100, 101, 110, 111.
- Fields that are unused by a format are ignored.
- Range checks, any failure giving err_code 2:
  - I, load and store: imm[12] must equal imm[11].
  - Shifts: imm[12:5] must be 0.
  - Branch: imm[0] must be 0.
- An error (illegal code or range) produces no write; the FSM goes to ERR with `err` = 1. ERR is left only via `start` or reset.
- After a successful write, the address pointer and `count` increment.
- `in_last` accepted → the FSM goes to IDLE, or to PAD when padding is built.
- `count` reaches DEPTH without `in_last` → the FSM goes to FULL and `done` pulses.
  - `in_valid` is ignored while in FULL.
  - A handshake attempt is impossible because `in_ready` = 0, so `err_code` 3 is set only if `in_valid` && `in_last` = 0 is seen in FULL.
- In IDLE, `in_ready` = 0.

## Timing
- Reset values: `in_ready` 0, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `done` 0, `err` 0, `err_code` 0, `count` 0.
- Latency: a handshake on edge N → `imem_we` = 1 with registered addr/data for the cycle after N. `count` updates on the same edge.
- Throughput is one instruction per cycle; back-to-back handshakes produce consecutive addresses.
- `done` pulses in the cycle following the final write, whether from last, DEPTH or the end of PAD.
- `start` in the same cycle as `in_valid`: the instruction is not accepted. A pending write from the previous cycle still completes.
- `rst_n` low mid-load: immediate return to reset values, and any write in flight is dropped.
- `imem_addr` wraps are impossible because DEPTH ≤ 2^AW.

## Configuration
- `ENC_NOP_PAD_EN` defined:
  - After the `in_last` write, the FSM enters PAD.
  - It writes NOP 0x00000013 (addi x0,x0,0) to each remaining address, one per cycle, until `count` = DEPTH.
  - It then pulses `done` and returns to IDLE. `in_ready` = 0 during PAD.
- `ENC_NOP_PAD_EN` undefined: there is no PAD state. `done` pulses one cycle after the last write, and unwritten words keep their prior contents.

## Test plan
- Basic encodings: `start`, then ADD x3,x1,x2; ADDI x1,x0,5; SRAI x5,x5,3 (last).
  - Writes: addr 0 = 0x002081B3, addr 1 = 0x00500093, addr 2 = 0x4032D293.
  - `done` pulses one cycle after the addr 2 write.
- Store and branch: SW x2,8(x1) → 0x0020A423; BEQ x1,x2,-8 → 0xFE208CE3.
- Errors:
  - op_sel = 27 → no write, `err` = 1, `err_code` = 1, `in_ready` = 0 until `start`.
  - ADDI imm = 13'h0800 → `err_code` 2.
  - BEQ imm = 5 → `err_code` 2.
- Overflow: with DEPTH = 4, five instructions without last → four writes, `done`, FULL. The fifth instruction is never accepted and `err_code` = 3.
- Restart and reset:
  - `start` during LOAD after 2 writes → the next write goes to addr 0 and `count` restarts at 1.
  - `rst_n` low mid-stream → all outputs return to reset values.
- With `ENC_NOP_PAD_EN`, DEPTH = 8 and 3 instructions: addrs 3–7 = 0x00000013, then `done` at cycle 9 after the first write.

Source files
------------

// File: rtl/instr_stream_encoder_if.sv
`default_nettype none
// ============================================================================
// Interface : instr_stream_encoder_if
// Purpose   : Symbolic RV32I instruction stream with valid/ready handshake.
// Revision  : 1.0 - initial release
// ============================================================================
interface instr_stream_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_last;
   logic [4:0]  op_sel;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [12:0] imm;

   modport master (
      output in_valid, in_last, op_sel, rd, rs1, rs2, imm,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_last, op_sel, rd, rs1, rs2, imm,
      output in_ready
   );
endinterface
`default_nettype wire

// File: rtl/instr_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_stream_encoder
// Purpose  : Encodes symbolic RV32I instructions into machine words and writes
//            them to instruction memory sequentially from word 0.
// Options  : ENC_NOP_PAD_EN - after the last instruction, fill the remaining
//            words with NOP before signalling done.
// Revision : 1.0 - initial release
// ============================================================================
module instr_stream_encoder #(
   parameter int AW    = 8,
   parameter int DEPTH = 256
) (
   input  wire                   clk,
   input  wire                   rst_n,
   input  wire                   start,
   instr_stream_encoder_if.slave s_in,
   output logic                  imem_we,
   output logic [AW-1:0]         imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  done,
   output logic                  err,
   output logic [1:0]            err_code,
   output logic [AW:0]           count
);

   localparam logic [AW:0] c_depth       = (AW+1)'(DEPTH);
   localparam logic [1:0]  c_err_illegal = 2'd1;
   localparam logic [1:0]  c_err_range   = 2'd2;
   localparam logic [1:0]  c_err_ovf     = 2'd3;
`ifdef ENC_NOP_PAD_EN
   localparam logic [31:0] c_nop         = 32'h0000_0013;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_PAD = 3'd2, ST_FULL = 3'd3, ST_ERR = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_FULL = 3'd3, ST_ERR = 3'd4
   } state_t;
`endif

   typedef enum logic [2:0] {
      F_R = 3'd0, F_I = 3'd1, F_SH = 3'd2, F_LD = 3'd3,
      F_ST = 3'd4, F_BR = 3'd5, F_BAD = 3'd6
   } fmt_t;

   state_t      r_state;
   state_t      w_next;
   logic [AW-1:0] r_ptr;
   logic        r_final;
   logic        w_hs;
   logic [AW:0] w_cnt_inc;
   fmt_t        w_fmt;
   logic [2:0]  w_f3;
   logic        w_alt;
   logic [31:0] w_enc;
   logic        w_range_err;
   logic        w_write;
   logic [31:0] w_wdata;
   logic        w_final;
   logic        w_err_set;
   logic [1:0]  w_err_code;

   assign s_in.in_ready = (r_state == ST_LOAD) && (count < c_depth) && !start;
   assign w_hs          = s_in.in_valid && s_in.in_ready;
   assign w_cnt_inc     = count + 1'b1;

   // Mnemonic code -> format, funct3 and the funct7[5] "alternate" bit
   always_comb begin
      w_fmt = F_BAD;
      w_f3  = 3'b000;
      w_alt = 1'b0;
      case (s_in.op_sel)
         5'd0:  begin w_fmt = F_R;  w_f3 = 3'b000; end
         5'd1:  begin w_fmt = F_R;  w_f3 = 3'b000; w_alt = 1'b1; end
         5'd2:  begin w_fmt = F_R;  w_f3 = 3'b001; end
         5'd3:  begin w_fmt = F_R;  w_f3 = 3'b100; end
         5'd4:  begin w_fmt = F_R;  w_f3 = 3'b101; end
         5'd5:  begin w_fmt = F_R;  w_f3 = 3'b101; w_alt = 1'b1; end
         5'd6:  begin w_fmt = F_R;  w_f3 = 3'b110; end
         5'd7:  begin w_fmt = F_R;  w_f3 = 3'b111; end
         5'd8:  begin w_fmt = F_I;  w_f3 = 3'b000; end
         5'd9:  begin w_fmt = F_SH; w_f3 = 3'b001; end
         5'd10: begin w_fmt = F_SH; w_f3 = 3'b101; end
         5'd11: begin w_fmt = F_SH; w_f3 = 3'b101; w_alt = 1'b1; end
         5'd12: begin w_fmt = F_I;  w_f3 = 3'b110; end
         5'd13: begin w_fmt = F_I;  w_f3 = 3'b111; end
         5'd14: begin w_fmt = F_LD; w_f3 = 3'b000; end
         5'd15: begin w_fmt = F_LD; w_f3 = 3'b001; end
         5'd16: begin w_fmt = F_LD; w_f3 = 3'b010; end
         5'd17: begin w_fmt = F_ST; w_f3 = 3'b000; end
         5'd18: begin w_fmt = F_ST; w_f3 = 3'b001; end
         5'd19: begin w_fmt = F_ST; w_f3 = 3'b010; end
         5'd20: begin w_fmt = F_BR; w_f3 = 3'b000; end
         5'd21: begin w_fmt = F_BR; w_f3 = 3'b001; end
         5'd22: begin w_fmt = F_BR; w_f3 = 3'b100; end
         5'd23: begin w_fmt = F_BR; w_f3 = 3'b101; end
         5'd24: begin w_fmt = F_BR; w_f3 = 3'b110; end
         5'd25: begin w_fmt = F_BR; w_f3 = 3'b111; end
         default: w_fmt = F_BAD;
      endcase
   end

   always_comb begin
      w_enc       = 32'd0;
      w_range_err = 1'b0;
      case (w_fmt)
         F_R:  w_enc = {1'b0, w_alt, 5'd0, s_in.rs2, s_in.rs1, w_f3, s_in.rd, 7'b0110011};
         F_I: begin
            w_enc       = {s_in.imm[11:0], s_in.rs1, w_f3, s_in.rd, 7'b0010011};
            w_range_err = s_in.imm[12] != s_in.imm[11];
         end
         F_SH: begin
            w_enc       = {1'b0, w_alt, 5'd0, s_in.imm[4:0], s_in.rs1, w_f3, s_in.rd, 7'b0010011};
            w_range_err = |s_in.imm[12:5];
         end
         F_LD: begin
            w_enc       = {s_in.imm[11:0], s_in.rs1, w_f3, s_in.rd, 7'b0000011};
            w_range_err = s_in.imm[12] != s_in.imm[11];
         end
         F_ST: begin
            w_enc       = {s_in.imm[11:5], s_in.rs2, s_in.rs1, w_f3, s_in.imm[4:0], 7'b0100011};
            w_range_err = s_in.imm[12] != s_in.imm[11];
         end
         F_BR: begin
            w_enc       = {s_in.imm[12], s_in.imm[10:5], s_in.rs2, s_in.rs1, w_f3,
                           s_in.imm[4:1], s_in.imm[11], 7'b1100011};
            w_range_err = s_in.imm[0];
         end
         default: ;
      endcase
   end

   // start overrides every state, so nothing below it may write or flag errors
   always_comb begin
      w_next     = r_state;
      w_write    = 1'b0;
      w_wdata    = w_enc;
      w_final    = 1'b0;
      w_err_set  = 1'b0;
      w_err_code = c_err_illegal;
      if (start) begin
         w_next = ST_LOAD;
      end else begin
         case (r_state)
            ST_LOAD: begin
               if (w_hs) begin
                  if (w_fmt == F_BAD) begin
                     w_err_set  = 1'b1;
                     w_err_code = c_err_illegal;
                     w_next     = ST_ERR;
                  end else if (w_range_err) begin
                     w_err_set  = 1'b1;
                     w_err_code = c_err_range;
                     w_next     = ST_ERR;
                  end else begin
                     w_write = 1'b1;
                     if (s_in.in_last) begin
`ifdef ENC_NOP_PAD_EN
                        if (w_cnt_inc == c_depth) begin
                           w_final = 1'b1;
                           w_next  = ST_IDLE;
                        end else begin
                           w_next  = ST_PAD;
                        end
`else
                        w_final = 1'b1;
                        w_next  = ST_IDLE;
`endif
                     end else if (w_cnt_inc == c_depth) begin
                        w_final = 1'b1;
                        w_next  = ST_FULL;
                     end
                  end
               end
            end
`ifdef ENC_NOP_PAD_EN
            ST_PAD: begin
               w_write = 1'b1;
               w_wdata = c_nop;
               if (w_cnt_inc == c_depth) begin
                  w_final = 1'b1;
                  w_next  = ST_IDLE;
               end
            end
`endif
            ST_FULL: begin
               if (s_in.in_valid && !s_in.in_last) begin
                  w_err_set  = 1'b1;
                  w_err_code = c_err_ovf;
                  w_next     = ST_ERR;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // done trails the final write by one cycle via r_final
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= 32'd0;
         r_ptr      <= '0;
         count      <= '0;
         r_final    <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         err_code   <= 2'd0;
      end else begin
         imem_we <= w_write;
         r_final <= w_write && w_final;
         done    <= r_final;
         if (w_write) begin
            imem_addr  <= r_ptr;
            imem_wdata <= w_wdata;
            r_ptr      <= r_ptr + 1'b1;
            count      <= w_cnt_inc;
         end
         if (start) begin
            r_ptr    <= '0;
            count    <= '0;
            err      <= 1'b0;
            err_code <= 2'd0;
         end else if (w_err_set) begin
            err      <= 1'b1;
            err_code <= w_err_code;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_stream_encoder
// Purpose  : Directed and random programs against a behavioural encoder model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_stream_encoder;
   localparam int AW    = 4;
   localparam int DEPTH = 8;

   typedef struct packed {
      logic [4:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [12:0] imm;
      logic        last;
   } instr_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          done;
   logic          err;
   logic [1:0]    err_code;
   logic [AW:0]   count;

   instr_stream_encoder_if bus();

   instr_stream_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .s_in       (bus),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .done       (done),
      .err        (err),
      .err_code   (err_code),
      .count      (count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int done_n, done_cyc, last_wr_cyc, first_wr_cyc;
   logic [AW-1:0] wr_addr_q[$];
   logic [31:0]   wr_data_q[$];
   bit            bubbles;
   instr_t        prog[$];

   int alu_f3[8] = '{0, 0, 1, 4, 5, 5, 6, 7};
   int imm_f3[6] = '{0, 1, 5, 5, 6, 7};
   int br_f3[6]  = '{0, 1, 4, 5, 6, 7};

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (imem_we) begin
         if (wr_addr_q.size() == 0) first_wr_cyc = cyc;
         wr_addr_q.push_back(imem_addr);
         wr_data_q.push_back(imem_wdata);
         last_wr_cyc = cyc;
      end
      if (done) begin
         done_n++;
         done_cyc = cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Encoding built from the instruction-set tables with integer field arithmetic
   function automatic logic [31:0] ref_encode(input instr_t t, output int ecode);
      int op, rd, rs1, rs2, v, u, w, f3;
      op = int'(t.op); rd = int'(t.rd); rs1 = int'(t.rs1); rs2 = int'(t.rs2);
      v  = int'($signed(t.imm));
      u  = int'(t.imm);
      ecode = 0;
      w = 0;
      if (op < 8) begin
         w = (rs2 << 20) | (rs1 << 15) | (alu_f3[op] << 12) | (rd << 7) | 'h33;
         if (op == 1 || op == 5) w = w | 'h4000_0000;
      end else if (op < 14) begin
         f3 = imm_f3[op - 8];
         if (op >= 9 && op <= 11) begin
            if (u > 31) ecode = 2;
            w = ((u & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
            if (op == 11) w = w | 'h4000_0000;
         end else begin
            if (v < -2048 || v > 2047) ecode = 2;
            w = ((v & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
         end
      end else if (op < 17) begin
         if (v < -2048 || v > 2047) ecode = 2;
         w = ((v & 'hFFF) << 20) | (rs1 << 15) | ((op - 14) << 12) | (rd << 7) | 'h03;
      end else if (op < 20) begin
         if (v < -2048 || v > 2047) ecode = 2;
         w = (((v >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | ((op - 17) << 12)
           | ((v & 31) << 7) | 'h23;
      end else if (op < 26) begin
         if (v % 2 != 0) ecode = 2;
         w = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
           | (br_f3[op - 20] << 12) | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | 'h63;
      end else begin
         ecode = 1;
      end
      return 32'(w);
   endfunction

   function automatic instr_t mk(input int op, input int rd, input int rs1, input int rs2,
                                 input int imm, input bit last);
      instr_t t;
      t.op = 5'(op); t.rd = 5'(rd); t.rs1 = 5'(rs1); t.rs2 = 5'(rs2);
      t.imm = 13'(imm); t.last = last;
      return t;
   endfunction

   function automatic instr_t rand_instr();
      instr_t t;
      logic [11:0] x;
      t.op  = (($urandom % 10) == 0) ? 5'(26 + $urandom % 6) : 5'($urandom % 26);
      t.rd  = 5'($urandom); t.rs1 = 5'($urandom); t.rs2 = 5'($urandom);
      x     = 12'($urandom);
      if (($urandom % 8) == 0)          t.imm = 13'($urandom);
      else if (t.op >= 9 && t.op <= 11) t.imm = 13'($urandom % 32);
      else if (t.op >= 20)              t.imm = 13'($urandom) & 13'h1FFE;
      else                              t.imm = {x[11], x};
      t.last = 1'b0;
      return t;
   endfunction

   task automatic drive(input instr_t t, input bit valid);
      bus.op_sel = t.op; bus.rd = t.rd; bus.rs1 = t.rs1; bus.rs2 = t.rs2;
      bus.imm = t.imm; bus.in_last = t.last; bus.in_valid = valid;
   endtask

   task automatic send(input instr_t t);
      bit ok, r;
      ok = 0;
      if (bubbles) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      drive(t, 1'b1);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk); r = bus.in_ready;
         @(posedge clk); #1;
         if (r) begin ok = 1; break; end
      end
      bus.in_valid = 1'b0;
      if (!ok) check("hs_timeout", 32'd0, 32'd1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic clear_mon();
      wr_addr_q.delete(); wr_data_q.delete();
      done_n = 0; done_cyc = 0; last_wr_cyc = 0; first_wr_cyc = 0;
   endtask

   task automatic run_prog(input string name);
      logic [AW-1:0] ea[$];
      logic [31:0]   ed[$];
      int cnt = 0, n_acc = 0, code = 0, ec;
      bit e_err = 0, e_done = 0, by_last = 0, probe = 0, e_ready;
      instr_t pt;
      logic [31:0] w;
      pt = '0;
      for (int i = 0; i < prog.size(); i++) begin
         if (cnt == DEPTH) begin
            if (!prog[i].last) begin probe = 1; e_err = 1; code = 3; pt = prog[i]; end
            break;
         end
         n_acc++;
         w = ref_encode(prog[i], ec);
         if (ec != 0) begin e_err = 1; code = ec; break; end
         ea.push_back(AW'(cnt)); ed.push_back(w); cnt++;
         if (prog[i].last) begin
`ifdef ENC_NOP_PAD_EN
            while (cnt < DEPTH) begin ea.push_back(AW'(cnt)); ed.push_back(32'h13); cnt++; end
`endif
            e_done = 1; by_last = 1;
            break;
         end
         if (cnt == DEPTH) e_done = 1;
      end
      e_ready = !e_err && !by_last && (cnt < DEPTH);

      clear_mon();
      pulse_start();
      for (int i = 0; i < n_acc; i++) send(prog[i]);
      if (probe) begin
         drive(pt, 1'b1);
         @(negedge clk); check({name, "_full_ready"}, 32'(bus.in_ready), 32'd0);
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
      end
      repeat (DEPTH + 4) begin @(posedge clk); #1; end

      check({name, "_nwr"}, 32'(wr_addr_q.size()), 32'(ea.size()));
      for (int i = 0; i < ea.size() && i < wr_addr_q.size(); i++) begin
         check($sformatf("%s_addr%0d", name, i), 32'(wr_addr_q[i]), 32'(ea[i]));
         check($sformatf("%s_data%0d", name, i), wr_data_q[i], ed[i]);
      end
      check({name, "_done_n"}, 32'(done_n), 32'(e_done));
      if (e_done && wr_addr_q.size() > 0)
         check({name, "_done_lat"}, 32'(done_cyc - last_wr_cyc), 32'd1);
      check({name, "_err"}, 32'(err), 32'(e_err));
      check({name, "_code"}, 32'(err_code), 32'(code));
      check({name, "_count"}, 32'(count), 32'(cnt));
      check({name, "_ready"}, 32'(bus.in_ready), 32'(e_ready));
   endtask

   task automatic check_reset_vals(input string name);
      check({name, "_we"}, 32'(imem_we), 32'd0);
      check({name, "_addr"}, 32'(imem_addr), 32'd0);
      check({name, "_wdata"}, imem_wdata, 32'd0);
      check({name, "_done"}, 32'(done), 32'd0);
      check({name, "_err"}, 32'(err), 32'd0);
      check({name, "_code"}, 32'(err_code), 32'd0);
      check({name, "_count"}, 32'(count), 32'd0);
      check({name, "_ready"}, 32'(bus.in_ready), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      instr_t a, b, x, y;
      int ec, len;
      rst_n = 1'b0; start = 1'b0; bubbles = 0;
      drive('0, 1'b0);
      clear_mon();
      repeat (3) begin @(posedge clk); #1; end
      check_reset_vals("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Reference program from the instruction listing
      prog = '{mk(0, 3, 1, 2, 0, 0), mk(8, 1, 0, 0, 5, 0), mk(11, 5, 5, 0, 3, 1)};
      run_prog("basic");
      check("basic_w0", wr_data_q[0], 32'h002081B3);
      check("basic_w1", wr_data_q[1], 32'h00500093);
      check("basic_w2", wr_data_q[2], 32'h4032D293);
`ifdef ENC_NOP_PAD_EN
      check("pad_done_cyc", 32'(done_cyc - first_wr_cyc + 1), 32'd9);
`else
      check("basic_done_cyc", 32'(done_cyc - first_wr_cyc + 1), 32'd4);
`endif

      prog = '{mk(19, 0, 1, 2, 8, 0), mk(20, 0, 1, 2, -8, 1)};
      run_prog("stbr");
      check("stbr_sw", wr_data_q[0], 32'h0020A423);
      check("stbr_beq", wr_data_q[1], 32'hFE208CE3);

      prog = '{mk(0, 1, 2, 3, 0, 0), mk(27, 1, 1, 1, 0, 0), mk(0, 1, 2, 3, 0, 1)};
      run_prog("illegal");
      check("illegal_code", 32'(err_code), 32'd1);
      prog = '{mk(8, 1, 0, 0, 'h0800, 1)};
      run_prog("addi_rng");
      check("addi_rng_code", 32'(err_code), 32'd2);
      prog = '{mk(20, 0, 1, 2, 5, 1)};
      run_prog("beq_rng");

      prog.delete();
      for (int i = 0; i <= DEPTH; i++) prog.push_back(mk(8, i, i, 0, i, 0));
      run_prog("ovf");
      check("ovf_code", 32'(err_code), 32'd3);

      // start while an instruction is offered: it is not taken, pending write completes
      a = mk(0, 1, 2, 3, 0, 0); b = mk(6, 4, 5, 6, 0, 0);
      x = mk(7, 7, 7, 7, 0, 0); y = mk(3, 9, 10, 11, 0, 0);
      clear_mon();
      pulse_start();
      send(a); send(b);
      start = 1'b1; drive(x, 1'b1);
      @(negedge clk); check("restart_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      send(y);
      repeat (3) begin @(posedge clk); #1; end
      check("restart_nwr", 32'(wr_addr_q.size()), 32'd3);
      check("restart_a1", 32'(wr_addr_q[1]), 32'd1);
      check("restart_d1", wr_data_q[1], ref_encode(b, ec));
      check("restart_a2", 32'(wr_addr_q[2]), 32'd0);
      check("restart_d2", wr_data_q[2], ref_encode(y, ec));
      check("restart_count", 32'(count), 32'd1);

      // asynchronous reset with a write in flight
      clear_mon();
      pulse_start();
      send(a); send(b);
      rst_n = 1'b0;
      #1;
      check_reset_vals("midrst");
      @(negedge clk);
      check("midrst_nwr", 32'(wr_addr_q.size()), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      bubbles = 1;
      for (int p = 0; p < 40; p++) begin
         prog.delete();
         len = $urandom_range(1, DEPTH + 2);
         for (int i = 0; i < len; i++) prog.push_back(rand_instr());
         if (($urandom % 4) != 0) prog[len - 1].last = 1'b1;
         run_prog($sformatf("rnd%0d", p));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
